// File: rtl/layer_mac_sched.sv
// layer_mac_sched: time-multiplexed scheduler for one fully-connected layer.
// One float multiplier and one float adder are shared by all output nodes.
// For each node the block streams activations and weights from 1-cycle-latency
// memories, accumulates in strict index order (bias last), applies ReLU, and
// presents the result on a valid/ready port.
//
// Float units: IEEE-754 single precision, round-to-nearest-even. Subnormal
// inputs are treated as zero, and results below the normal range flush to a
// signed zero. NaN operands are passed through unchanged.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin a layer (sampled only when idle)
//   busy, done         layer in progress / one-cycle completion pulse
//   act_addr, act_data activation memory address / data (next cycle)
//   w_addr, w_data     weight+bias memory address / data (next cycle)
//   out_valid, out_ready, out_idx, out_data   result handshake

module float_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sa, sb, sy;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic [47:0] prod;
    logic [9:0]  e_n;
    logic [22:0] m_n;
    logic        guard, sticky, rnd;
    logic [32:0] rounded;

    always_comb begin
        {sa, ea, ma} = a;
        {sb, eb, mb} = b;
        sy   = sa ^ sb;
        prod = {1'b1, ma} * {1'b1, mb};
        if (prod[47]) begin
            m_n    = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e_n    = 10'(ea) + 10'(eb) - 10'd126;
        end else begin
            m_n    = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            e_n    = 10'(ea) + 10'(eb) - 10'd127;
        end
        rnd = guard & (sticky | m_n[0]);
        // Mantissa carry-out ripples straight into the exponent field.
        rounded = {e_n, m_n} + 33'(rnd);

        if (ea == 8'hff && ma != 23'h0) begin
            y = a;
        end else if (eb == 8'hff && mb != 23'h0) begin
            y = b;
        end else if ((ea == 8'hff && eb == 8'h0) || (eb == 8'hff && ea == 8'h0)) begin
            y = 32'h7fc0_0000;
        end else if (ea == 8'hff || eb == 8'hff) begin
            y = {sy, 8'hff, 23'h0};
        end else if (ea == 8'h0 || eb == 8'h0) begin
            y = {sy, 31'h0};
        end else if (rounded[32] || rounded[31:23] == 9'h0) begin
            y = {sy, 31'h0};
        end else if (rounded[31:23] >= 9'd255) begin
            y = {sy, 8'hff, 23'h0};
        end else begin
            y = {sy, rounded[30:0]};
        end
    end
endmodule

module float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sa, sb, s_big;
    logic [7:0]  ea, eb, e_big, e_sml, d;
    logic [22:0] ma, mb, m_big, m_sml;
    logic [49:0] sh;
    logic [26:0] bm, sm, norm;
    logic [27:0] raw;
    logic [4:0]  lz;
    logic        found, zero, guard, sticky, rnd;
    logic [9:0]  e_n;
    logic [32:0] rounded;

    always_comb begin
        {sa, ea, ma} = a;
        {sb, eb, mb} = b;
        if ({ea, ma} >= {eb, mb}) begin
            s_big = sa; e_big = ea; m_big = ma; e_sml = eb; m_sml = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb; e_sml = ea; m_sml = ma;
        end
        d  = e_big - e_sml;
        // 24-bit significand plus guard, round and sticky bits.
        bm = {1'b1, m_big, 3'b000};
        sh = {1'b1, m_sml, 26'h0} >> d[4:0];
        if (d >= 8'd27) sm = 27'd1;
        else            sm = {sh[49:24], |sh[23:0]};
        raw = (sa ^ sb) ? {1'b0, bm} - {1'b0, sm} : {1'b0, bm} + {1'b0, sm};

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (raw[i] && !found) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (raw[27]) begin
            norm = {raw[27:2], raw[1] | raw[0]};
            e_n  = 10'(e_big) + 10'd1;
        end else begin
            norm = raw[26:0] << lz;
            e_n  = 10'(e_big) - 10'(lz);
        end
        zero    = !norm[26];
        guard   = norm[2];
        sticky  = norm[1] | norm[0];
        rnd     = guard & (sticky | norm[3]);
        rounded = {e_n, norm[25:3]} + 33'(rnd);

        if (ea == 8'hff && ma != 23'h0) begin
            y = a;
        end else if (eb == 8'hff && mb != 23'h0) begin
            y = b;
        end else if (ea == 8'hff && eb == 8'hff) begin
            y = (sa == sb) ? a : 32'h7fc0_0000;
        end else if (ea == 8'hff) begin
            y = a;
        end else if (eb == 8'hff) begin
            y = b;
        end else if (ea == 8'h0 && eb == 8'h0) begin
            y = {sa & sb, 31'h0};
        end else if (ea == 8'h0) begin
            y = b;
        end else if (eb == 8'h0) begin
            y = a;
        end else if (zero) begin
            y = 32'h0;  // exact cancellation gives +0
        end else if (rounded[32] || rounded[31:23] == 9'h0) begin
            y = {s_big, 31'h0};
        end else if (rounded[31:23] >= 9'd255) begin
            y = {s_big, 8'hff, 23'h0};
        end else begin
            y = {s_big, rounded[30:0]};
        end
    end
endmodule

module layer_mac_sched #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 8,
    parameter int AW    = 4,
    parameter int WW    = 8,
    parameter int OW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] act_addr,
    input  logic [31:0]   act_data,
    output logic [WW-1:0] w_addr,
    input  logic [31:0]   w_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_idx,
    output logic [31:0]   out_data
);
    localparam int KW = $clog2(N_IN + 2);
    localparam logic [KW-1:0] KBias    = KW'(N_IN);
    localparam logic [KW-1:0] KLast    = KW'(N_IN + 1);
    localparam logic [WW-1:0] Stride   = WW'(N_IN + 1);
    localparam logic [OW-1:0] LastNode = OW'(N_OUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StEmit, StDone} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [OW-1:0] node_q, node_d;
    logic [WW-1:0] base_q, base_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   prod, addend, sum;

    float_mult u_mult (
        .a (act_data),
        .b (w_data),
        .y (prod)
    );

    // Data arriving at k belongs to the read issued at k-1; k==KLast is the bias.
    assign addend = (k_q == KLast) ? w_data : prod;

    float_adder u_add (
        .a (acc_q),
        .b (addend),
        .y (sum)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        node_d    = node_q;
        base_d    = base_q;
        acc_d     = acc_q;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = 32'h0;
        act_addr  = '0;
        w_addr    = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    k_d     = '0;
                    node_d  = '0;
                    base_d  = '0;
                    acc_d   = 32'h0;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (k_q <= KBias) begin
                    w_addr   = base_q + WW'(k_q);
                    act_addr = (k_q < KBias) ? AW'(k_q) : '0;
                end
                if (k_q != '0) acc_d = sum;
                if (k_q == KLast) state_d = StEmit;
                else              k_d = k_q + 1'b1;
            end
            StEmit: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = node_q;
                out_data  = acc_q[31] ? 32'h0 : acc_q;
                if (out_ready) begin
                    if (node_q == LastNode) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        node_d  = node_q + 1'b1;
                        base_d  = base_q + Stride;
                        acc_d   = 32'h0;
                        k_d     = '0;
                    end
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            node_q  <= '0;
            base_q  <= '0;
            acc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            node_q  <= node_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: doc/layer_mac_sched.md
# layer_mac_sched

Time-multiplexed scheduler for one fully-connected layer of the ECG network. It uses a single `float_mult` / `float_adder` pair, instantiated inside the block, to compute every output node of the layer in turn. For each node it:
- fetches activations and weights from synchronous-read memories,
- accumulates the weighted sum plus bias,
- applies ReLU,
- hands the result out over a valid/ready port.

It sits between the activation buffer / weight ROM and the next layer's activation buffer. It replaces a fully unrolled per-node adder tree where area matters more than latency.

## Interface
Parameters:
- N_IN, 15, inputs per node (activations per layer input)
- N_OUT, 8, output nodes per layer
- AW, 4, activation address width (2^AW >= N_IN)
- WW, 8, weight address width (2^WW >= N_OUT*(N_IN+1))
- OW, 3, output index width (2^OW >= N_OUT)

Ports (one clock, `clk`; reset `rst_n` is synchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse after the last node's handshake
- act_addr  out  AW  activation read address
- act_data  in  32  IEEE-754 single; valid the cycle after act_addr
- w_addr  out  WW  weight/bias read address
- w_data  in  32  IEEE-754 single; valid the cycle after w_addr
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid & out_ready at a rising edge
- out_idx  out  OW  node index of out_data
- out_data  out  32  ReLU(sum); sign bit 1 -> 32'h0

## Operation
- Weight memory layout: node n occupies words n*(N_IN+1) .. n*(N_IN+1)+N_IN. The last word of each node is its bias. The base address is advanced by adding N_IN+1 per node (no multiplier).
- States: IDLE, RUN, EMIT, DONE.
- IDLE: outputs low/zero. On start=1 -> RUN with node=0, base=0, k=0, acc=32'h0.
- RUN: counter k runs 0..N_IN+1, one step per cycle.
  - Address issue, while k<=N_IN: w_addr=base+k. act_addr=k for k<N_IN, 0 for k=N_IN.
  - Accumulate, while k>=1, with j=k-1:
    - j<N_IN: acc <= acc + act_data*w_data, via float_mult then float_adder.
    - j=N_IN: acc <= acc + w_data (bias).
  - At k=N_IN+1, after the final update -> EMIT.
- Summation order is strictly sequential: index 0 first, bias last. The golden model must use the same order.
- EMIT: out_valid=1, out_idx=node, out_data = acc[31] ? 0 : acc. These are held stable until handshake.
  - On handshake with node<N_OUT-1: node++, base+=N_IN+1, acc=0, k=0 -> RUN.
  - On handshake with node=N_OUT-1: -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored. out_ready without out_valid is ignored.
- NaN/Inf propagate through the float units unchanged. A NaN with sign 0 passes ReLU as-is.

## Timing
- Reset: every output (busy, done, out_valid, out_idx, out_data, act_addr, w_addr) is 0 at the first edge with rst_n=0. rst_n low in any state forces IDLE at that edge and discards the partial node.
- Start at edge t -> RUN from t+1. act_addr=0 and w_addr=0 appear in cycle t+1.
- First out_valid: cycle t+1+(N_IN+2).
- Per node, with out_ready tied high: N_IN+3 cycles.
- Default parameters: last handshake at cycle t+144; done is high at t+145.
- Backpressure: each cycle of out_ready=0 in EMIT adds exactly one cycle. No memory reads are issued in EMIT.
- Memory read latency is exactly 1 cycle; the block never issues a read whose data it does not consume.

## Test plan
Scenarios 1–3 use N_IN=2, N_OUT=2, acts={1.0 (3F800000), 2.0 (40000000)}, and weights:
- node0: 0.5, 1.0, bias 1.0
- node1: -1.0, -1.0, bias 0.5

1. Basic layer, out_ready=1 -> idx0 data 40600000 (3.5) at start+5; idx1 data 00000000 (-2.5 clipped) at start+10; done at start+11.
2. Backpressure: out_ready=0 for 3 cycles on node0 -> out_data/out_idx stay stable; node1 emits 3 cycles later; w_addr does not advance during the stall.
3. Address sequence check -> w_addr 0,1,2 then 3,4,5; act_addr 0,1,0 for each node.
4. rst_n=0 in the middle of RUN of node 1 -> all outputs 0 next edge. A fresh start reproduces the scenario 1 results exactly.
5. start pulsed during RUN and during EMIT -> ignored; exactly N_OUT handshakes and one done.
6. Default parameters, random weights against a sequential-order float model -> bit-exact for all 8 nodes; done at start+145 with out_ready tied high.
